// File: rtl/aes_pkg.sv
// Shared AES constants, types and word helpers used by the key schedule and round datapath.
package aes_pkg;

  localparam int unsigned NR       = 10;
  localparam int unsigned RK_IDX_W = 4;

  typedef logic [127:0] rkey_t;
  typedef logic [NR:1][7:0] rcon_t;

  // Element [i] is the round constant for round key i.
  localparam rcon_t RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                            8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ke_state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// ECU-side bus of the key expander: start/key request plus round-key read port and status.
interface aes_key_expander_if;
  import aes_pkg::*;

  logic                start_key_exp;
  rkey_t               key_in;
  logic [RK_IDX_W-1:0] round_sel;
  rkey_t               round_key;
  logic                key_expanded;
  logic                busy;

  modport master (
    output start_key_exp, key_in, round_sel,
    input  round_key, key_expanded, busy
  );

  modport slave (
    input  start_key_exp, key_in, round_sel,
    output round_key, key_expanded, busy
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] sub_c
);
  always_comb begin
    sub_c = 8'h00;
    case (din)
      8'h00: sub_c = 8'h63; 8'h01: sub_c = 8'h7c; 8'h02: sub_c = 8'h77; 8'h03: sub_c = 8'h7b; 8'h04: sub_c = 8'hf2; 8'h05: sub_c = 8'h6b; 8'h06: sub_c = 8'h6f; 8'h07: sub_c = 8'hc5;
      8'h08: sub_c = 8'h30; 8'h09: sub_c = 8'h01; 8'h0a: sub_c = 8'h67; 8'h0b: sub_c = 8'h2b; 8'h0c: sub_c = 8'hfe; 8'h0d: sub_c = 8'hd7; 8'h0e: sub_c = 8'hab; 8'h0f: sub_c = 8'h76;
      8'h10: sub_c = 8'hca; 8'h11: sub_c = 8'h82; 8'h12: sub_c = 8'hc9; 8'h13: sub_c = 8'h7d; 8'h14: sub_c = 8'hfa; 8'h15: sub_c = 8'h59; 8'h16: sub_c = 8'h47; 8'h17: sub_c = 8'hf0;
      8'h18: sub_c = 8'had; 8'h19: sub_c = 8'hd4; 8'h1a: sub_c = 8'ha2; 8'h1b: sub_c = 8'haf; 8'h1c: sub_c = 8'h9c; 8'h1d: sub_c = 8'ha4; 8'h1e: sub_c = 8'h72; 8'h1f: sub_c = 8'hc0;
      8'h20: sub_c = 8'hb7; 8'h21: sub_c = 8'hfd; 8'h22: sub_c = 8'h93; 8'h23: sub_c = 8'h26; 8'h24: sub_c = 8'h36; 8'h25: sub_c = 8'h3f; 8'h26: sub_c = 8'hf7; 8'h27: sub_c = 8'hcc;
      8'h28: sub_c = 8'h34; 8'h29: sub_c = 8'ha5; 8'h2a: sub_c = 8'he5; 8'h2b: sub_c = 8'hf1; 8'h2c: sub_c = 8'h71; 8'h2d: sub_c = 8'hd8; 8'h2e: sub_c = 8'h31; 8'h2f: sub_c = 8'h15;
      8'h30: sub_c = 8'h04; 8'h31: sub_c = 8'hc7; 8'h32: sub_c = 8'h23; 8'h33: sub_c = 8'hc3; 8'h34: sub_c = 8'h18; 8'h35: sub_c = 8'h96; 8'h36: sub_c = 8'h05; 8'h37: sub_c = 8'h9a;
      8'h38: sub_c = 8'h07; 8'h39: sub_c = 8'h12; 8'h3a: sub_c = 8'h80; 8'h3b: sub_c = 8'he2; 8'h3c: sub_c = 8'heb; 8'h3d: sub_c = 8'h27; 8'h3e: sub_c = 8'hb2; 8'h3f: sub_c = 8'h75;
      8'h40: sub_c = 8'h09; 8'h41: sub_c = 8'h83; 8'h42: sub_c = 8'h2c; 8'h43: sub_c = 8'h1a; 8'h44: sub_c = 8'h1b; 8'h45: sub_c = 8'h6e; 8'h46: sub_c = 8'h5a; 8'h47: sub_c = 8'ha0;
      8'h48: sub_c = 8'h52; 8'h49: sub_c = 8'h3b; 8'h4a: sub_c = 8'hd6; 8'h4b: sub_c = 8'hb3; 8'h4c: sub_c = 8'h29; 8'h4d: sub_c = 8'he3; 8'h4e: sub_c = 8'h2f; 8'h4f: sub_c = 8'h84;
      8'h50: sub_c = 8'h53; 8'h51: sub_c = 8'hd1; 8'h52: sub_c = 8'h00; 8'h53: sub_c = 8'hed; 8'h54: sub_c = 8'h20; 8'h55: sub_c = 8'hfc; 8'h56: sub_c = 8'hb1; 8'h57: sub_c = 8'h5b;
      8'h58: sub_c = 8'h6a; 8'h59: sub_c = 8'hcb; 8'h5a: sub_c = 8'hbe; 8'h5b: sub_c = 8'h39; 8'h5c: sub_c = 8'h4a; 8'h5d: sub_c = 8'h4c; 8'h5e: sub_c = 8'h58; 8'h5f: sub_c = 8'hcf;
      8'h60: sub_c = 8'hd0; 8'h61: sub_c = 8'hef; 8'h62: sub_c = 8'haa; 8'h63: sub_c = 8'hfb; 8'h64: sub_c = 8'h43; 8'h65: sub_c = 8'h4d; 8'h66: sub_c = 8'h33; 8'h67: sub_c = 8'h85;
      8'h68: sub_c = 8'h45; 8'h69: sub_c = 8'hf9; 8'h6a: sub_c = 8'h02; 8'h6b: sub_c = 8'h7f; 8'h6c: sub_c = 8'h50; 8'h6d: sub_c = 8'h3c; 8'h6e: sub_c = 8'h9f; 8'h6f: sub_c = 8'ha8;
      8'h70: sub_c = 8'h51; 8'h71: sub_c = 8'ha3; 8'h72: sub_c = 8'h40; 8'h73: sub_c = 8'h8f; 8'h74: sub_c = 8'h92; 8'h75: sub_c = 8'h9d; 8'h76: sub_c = 8'h38; 8'h77: sub_c = 8'hf5;
      8'h78: sub_c = 8'hbc; 8'h79: sub_c = 8'hb6; 8'h7a: sub_c = 8'hda; 8'h7b: sub_c = 8'h21; 8'h7c: sub_c = 8'h10; 8'h7d: sub_c = 8'hff; 8'h7e: sub_c = 8'hf3; 8'h7f: sub_c = 8'hd2;
      8'h80: sub_c = 8'hcd; 8'h81: sub_c = 8'h0c; 8'h82: sub_c = 8'h13; 8'h83: sub_c = 8'hec; 8'h84: sub_c = 8'h5f; 8'h85: sub_c = 8'h97; 8'h86: sub_c = 8'h44; 8'h87: sub_c = 8'h17;
      8'h88: sub_c = 8'hc4; 8'h89: sub_c = 8'ha7; 8'h8a: sub_c = 8'h7e; 8'h8b: sub_c = 8'h3d; 8'h8c: sub_c = 8'h64; 8'h8d: sub_c = 8'h5d; 8'h8e: sub_c = 8'h19; 8'h8f: sub_c = 8'h73;
      8'h90: sub_c = 8'h60; 8'h91: sub_c = 8'h81; 8'h92: sub_c = 8'h4f; 8'h93: sub_c = 8'hdc; 8'h94: sub_c = 8'h22; 8'h95: sub_c = 8'h2a; 8'h96: sub_c = 8'h90; 8'h97: sub_c = 8'h88;
      8'h98: sub_c = 8'h46; 8'h99: sub_c = 8'hee; 8'h9a: sub_c = 8'hb8; 8'h9b: sub_c = 8'h14; 8'h9c: sub_c = 8'hde; 8'h9d: sub_c = 8'h5e; 8'h9e: sub_c = 8'h0b; 8'h9f: sub_c = 8'hdb;
      8'ha0: sub_c = 8'he0; 8'ha1: sub_c = 8'h32; 8'ha2: sub_c = 8'h3a; 8'ha3: sub_c = 8'h0a; 8'ha4: sub_c = 8'h49; 8'ha5: sub_c = 8'h06; 8'ha6: sub_c = 8'h24; 8'ha7: sub_c = 8'h5c;
      8'ha8: sub_c = 8'hc2; 8'ha9: sub_c = 8'hd3; 8'haa: sub_c = 8'hac; 8'hab: sub_c = 8'h62; 8'hac: sub_c = 8'h91; 8'had: sub_c = 8'h95; 8'hae: sub_c = 8'he4; 8'haf: sub_c = 8'h79;
      8'hb0: sub_c = 8'he7; 8'hb1: sub_c = 8'hc8; 8'hb2: sub_c = 8'h37; 8'hb3: sub_c = 8'h6d; 8'hb4: sub_c = 8'h8d; 8'hb5: sub_c = 8'hd5; 8'hb6: sub_c = 8'h4e; 8'hb7: sub_c = 8'ha9;
      8'hb8: sub_c = 8'h6c; 8'hb9: sub_c = 8'h56; 8'hba: sub_c = 8'hf4; 8'hbb: sub_c = 8'hea; 8'hbc: sub_c = 8'h65; 8'hbd: sub_c = 8'h7a; 8'hbe: sub_c = 8'hae; 8'hbf: sub_c = 8'h08;
      8'hc0: sub_c = 8'hba; 8'hc1: sub_c = 8'h78; 8'hc2: sub_c = 8'h25; 8'hc3: sub_c = 8'h2e; 8'hc4: sub_c = 8'h1c; 8'hc5: sub_c = 8'ha6; 8'hc6: sub_c = 8'hb4; 8'hc7: sub_c = 8'hc6;
      8'hc8: sub_c = 8'he8; 8'hc9: sub_c = 8'hdd; 8'hca: sub_c = 8'h74; 8'hcb: sub_c = 8'h1f; 8'hcc: sub_c = 8'h4b; 8'hcd: sub_c = 8'hbd; 8'hce: sub_c = 8'h8b; 8'hcf: sub_c = 8'h8a;
      8'hd0: sub_c = 8'h70; 8'hd1: sub_c = 8'h3e; 8'hd2: sub_c = 8'hb5; 8'hd3: sub_c = 8'h66; 8'hd4: sub_c = 8'h48; 8'hd5: sub_c = 8'h03; 8'hd6: sub_c = 8'hf6; 8'hd7: sub_c = 8'h0e;
      8'hd8: sub_c = 8'h61; 8'hd9: sub_c = 8'h35; 8'hda: sub_c = 8'h57; 8'hdb: sub_c = 8'hb9; 8'hdc: sub_c = 8'h86; 8'hdd: sub_c = 8'hc1; 8'hde: sub_c = 8'h1d; 8'hdf: sub_c = 8'h9e;
      8'he0: sub_c = 8'he1; 8'he1: sub_c = 8'hf8; 8'he2: sub_c = 8'h98; 8'he3: sub_c = 8'h11; 8'he4: sub_c = 8'h69; 8'he5: sub_c = 8'hd9; 8'he6: sub_c = 8'h8e; 8'he7: sub_c = 8'h94;
      8'he8: sub_c = 8'h9b; 8'he9: sub_c = 8'h1e; 8'hea: sub_c = 8'h87; 8'heb: sub_c = 8'he9; 8'hec: sub_c = 8'hce; 8'hed: sub_c = 8'h55; 8'hee: sub_c = 8'h28; 8'hef: sub_c = 8'hdf;
      8'hf0: sub_c = 8'h8c; 8'hf1: sub_c = 8'ha1; 8'hf2: sub_c = 8'h89; 8'hf3: sub_c = 8'h0d; 8'hf4: sub_c = 8'hbf; 8'hf5: sub_c = 8'he6; 8'hf6: sub_c = 8'h42; 8'hf7: sub_c = 8'h68;
      8'hf8: sub_c = 8'h41; 8'hf9: sub_c = 8'h99; 8'hfa: sub_c = 8'h2d; 8'hfb: sub_c = 8'h0f; 8'hfc: sub_c = 8'hb0; 8'hfd: sub_c = 8'h54; 8'hfe: sub_c = 8'hbb; 8'hff: sub_c = 8'h16;
    endcase
  end
endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: latches the cipher key, derives one round key per clock
// into an 11-entry register file, and exposes the file through a combinational read port.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aes_key_expander_if.slave  bus
);

  ke_state_t           state_q, state_d;
  logic [RK_IDX_W-1:0] cnt_q, cnt_d;
  logic                start_q;
  logic                busy_q, busy_d;
  logic                kexp_q, kexp_d;
  rkey_t               rk [0:NR];

  logic                rk_we;
  logic [RK_IDX_W-1:0] rk_widx;
  rkey_t               rk_wdata;

  logic                accept_c;
  logic [RK_IDX_W-1:0] prev_idx_c;
  rkey_t               prev_rk_c, next_rk_c;
  logic [31:0]         rot_c, sub_c, t_c, n0_c, n1_c, n2_c, n3_c;

  // One schedule step from the most recently written round key.
  assign prev_idx_c = cnt_q - RK_IDX_W'(1);
  assign prev_rk_c  = (prev_idx_c <= RK_IDX_W'(NR)) ? rk[prev_idx_c] : '0;
  assign rot_c      = rot_word(prev_rk_c[31:0]);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (.din(rot_c[8*g +: 8]), .sub_c(sub_c[8*g +: 8]));
  end

  assign t_c       = sub_c ^ {RCON[cnt_q], 24'h0};
  assign n0_c      = prev_rk_c[127:96] ^ t_c;
  assign n1_c      = prev_rk_c[95:64]  ^ n0_c;
  assign n2_c      = prev_rk_c[63:32]  ^ n1_c;
  assign n3_c      = prev_rk_c[31:0]   ^ n2_c;
  assign next_rk_c = {n0_c, n1_c, n2_c, n3_c};

  // Only a fresh rising edge outside EXPAND starts a new schedule.
  assign accept_c = bus.start_key_exp & ~start_q & (state_q != EXPAND);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    kexp_d   = kexp_q;
    rk_we    = 1'b0;
    rk_widx  = cnt_q;
    rk_wdata = next_rk_c;
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          state_d  = EXPAND;
          cnt_d    = RK_IDX_W'(1);
          busy_d   = 1'b1;
          kexp_d   = 1'b0;
          rk_we    = 1'b1;
          rk_widx  = '0;
          rk_wdata = bus.key_in;
        end
      end
      EXPAND: begin
        rk_we = 1'b1;
        cnt_d = cnt_q + RK_IDX_W'(1);
        if (cnt_q == RK_IDX_W'(NR)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          kexp_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      kexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= bus.start_key_exp;
      busy_q  <= busy_d;
      kexp_q  <= kexp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (rk_we) begin
      rk[rk_widx] <= rk_wdata;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.key_expanded = kexp_q;
  assign bus.round_key    = (bus.round_sel <= RK_IDX_W'(NR)) ? rk[bus.round_sel] : '0;

endmodule
